// File: rtl/cache_wr_hit_ctrl.sv
// Write-hit sequencer: lookup -> mark dirty -> snoop invalidate -> write-back.
// Optional ack timeout in INV enabled by `define CACHE_WR_HIT_ACK_TIMEOUT_EN.
module cache_wr_hit_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr_write,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cache_hit,
  output logic              bus_req,
  output logic [ADDR_W-1:0] inv_addr,
  input  logic              ack,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              dirty,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              timeout_err
);
  localparam int LINES = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MARK, INV, WB} state_t;
  state_t state, nxt;

  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic              lk_cnt;
  logic              done_q, overrun_q;
  logic [DATA_W-1:0] line_mem [LINES];
  logic [LINES-1:0]  dirty_bits;
  logic              to_hit;

`ifdef CACHE_WR_HIT_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_err_q;

  // Give up on the last waiting cycle unless ack arrives on it.
  assign to_hit = (state == INV) && !ack && (to_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt   <= (state == INV && !ack) ? to_cnt + 1'b1 : '0;
      to_err_q <= to_err_q | to_hit;
    end
  end
  assign timeout_err = to_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT != 0);
  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (wr) nxt = LOOKUP;
      LOOKUP:  if (cache_hit) nxt = MARK;
               else if (lk_cnt) nxt = IDLE;
      MARK:    nxt = INV;
      INV:     if (ack) nxt = WB;
               else if (to_hit) nxt = IDLE;
      WB:      if (mem_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req  = (state == INV);
    mem_wr   = (state == WB);
    inv_addr = bus_req ? a_q : '0;
    mem_addr = mem_wr ? a_q : '0;
    mem_data = mem_wr ? line_mem[a_q] : '0;
    busy     = (state != IDLE);
    done     = done_q;
    overrun  = overrun_q;
    dirty    = dirty_bits[a_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      d_q        <= '0;
      lk_cnt     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      dirty_bits <= '0;
    end else begin
      done_q    <= (state == WB) && mem_ack;
      overrun_q <= overrun_q | (wr && state != IDLE);
      if (state == IDLE && wr) begin
        a_q <= addr_write;
        d_q <= wr_data;
      end
      lk_cnt <= (state == LOOKUP);
      if (state == MARK)            dirty_bits[a_q] <= 1'b1;
      if (state == WB && mem_ack)   dirty_bits[a_q] <= 1'b0;
    end
  end

  // Line data is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == MARK) line_mem[a_q] <= d_q;
  end
endmodule
